// File: rtl/cmp_seq_ctrl_pkg.sv
// rtl/cmp_seq_ctrl_pkg.sv - shared definitions for the sequential magnitude comparator
// Purpose: FSM state encoding, cascade vector bit order and slice result codes.
// Ports: none (package).
package cmp_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Cascade / result vectors are packed {lt,eq,gt}.
   localparam int CAS_LT = 2;
   localparam int CAS_EQ = 1;
   localparam int CAS_GT = 0;

   localparam logic [2:0] CAS_RES_LT = 3'b100;
   localparam logic [2:0] CAS_RES_GT = 3'b001;

endpackage

// File: rtl/cmp_seq_ctrl_cmp3_slice.sv
// rtl/cmp_seq_ctrl_cmp3_slice.sv - combinational cascadable 3-bit magnitude comparator slice
// Purpose: compares one 3-bit slice of A and B; a tie passes the cascade input through.
// Ports:
//   i_a, i_b                     3-bit unsigned slices
//   i_cin_lt, i_cin_eq, i_cin_gt cascade input from lower slices
//   o_lt, o_eq, o_gt             cascade output
module cmp3_slice
   import cmp_seq_ctrl_pkg::*;
(
   input  logic [2:0] i_a,
   input  logic [2:0] i_b,
   input  logic       i_cin_lt,
   input  logic       i_cin_eq,
   input  logic       i_cin_gt,
   output logic       o_lt,
   output logic       o_eq,
   output logic       o_gt
);

   logic [2:0] w_out;

   // Ties forward the cascade unchanged, even illegal codes like 000 or 011,
   // so a chained block sees exactly what its seed was.
   always_comb begin
      w_out = {i_cin_lt, i_cin_eq, i_cin_gt};
      if (i_a > i_b) begin
         w_out = CAS_RES_GT;
      end else if (i_a < i_b) begin
         w_out = CAS_RES_LT;
      end
   end

   assign o_lt = w_out[CAS_LT];
   assign o_eq = w_out[CAS_EQ];
   assign o_gt = w_out[CAS_GT];

endmodule

// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - multi-cycle magnitude comparator controller, one 3-bit slice per cycle
// Purpose: captures A/B and a cascade seed on start, walks slices LSB first through a
//   single cmp3_slice with a registered cascade, and presents a held lt/eq/gt result.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start                    request, sampled in IDLE or DONE
//   a, b                     WIDTH-bit unsigned operands
//   cin_lt, cin_eq, cin_gt   cascade seed (010 for standalone use)
//   busy                     comparison running
//   done                     one-cycle result-valid pulse
//   lt, eq, gt               result, held until next accepted start
module cmp_seq_ctrl
   import cmp_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin_lt,
   input  logic             cin_eq,
   input  logic             cin_gt,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int NSLICE = WIDTH / 3;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   generate
      if (((WIDTH % 3) != 0) || (WIDTH < 3)) begin : g_width_chk
         $error("cmp_seq_ctrl: WIDTH must be a multiple of 3 and >= 3");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_cas;
   logic [2:0]       r_res;
   logic [IDX_W-1:0] r_idx;
   logic             w_accept;
   logic             w_last;
   logic [2:0]       w_sa;
   logic [2:0]       w_sb;
   logic [2:0]       w_slice_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = (r_idx == IDX_LAST);
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand slice select; a compare loop avoids a variable part-select
   // whose index width would not match the operand width.
   always_comb begin
      w_sa = '0;
      w_sb = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_sa = r_a[3*i +: 3];
            w_sb = r_b[3*i +: 3];
         end
      end
   end

   cmp3_slice u_slice (
      .i_a      (w_sa),
      .i_b      (w_sb),
      .i_cin_lt (r_cas[CAS_LT]),
      .i_cin_eq (r_cas[CAS_EQ]),
      .i_cin_gt (r_cas[CAS_GT]),
      .o_lt     (w_slice_out[CAS_LT]),
      .o_eq     (w_slice_out[CAS_EQ]),
      .o_gt     (w_slice_out[CAS_GT])
   );

   // The result register is written only on the last slice, so lt/eq/gt
   // stay at the previous answer for the whole RUN phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_cas <= '0;
         r_res <= '0;
         r_idx <= '0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_cas <= {cin_lt, cin_eq, cin_gt};
         r_idx <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_last) begin
            r_res <= w_slice_out;
         end else begin
            r_cas <= w_slice_out;
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);
   assign lt   = r_res[CAS_LT];
   assign eq   = r_res[CAS_EQ];
   assign gt   = r_res[CAS_GT];

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb/tb_cmp_seq_ctrl.sv - self-checking bench for cmp_seq_ctrl (WIDTH=9 and WIDTH=3)
module tb_cmp_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [8:0] a;
   logic [8:0] b;
   logic       cin_lt;
   logic       cin_eq;
   logic       cin_gt;
   logic       busy;
   logic       done;
   logic       lt;
   logic       eq;
   logic       gt;

   logic       start3;
   logic [2:0] a3;
   logic [2:0] b3;
   logic       busy3;
   logic       done3;
   logic       lt3;
   logic       eq3;
   logic       gt3;

   int         n_checks;
   int         n_pass;
   logic [2:0] exp_prev;

   cmp_seq_ctrl #(.WIDTH(9)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .cin_lt (cin_lt),
      .cin_eq (cin_eq),
      .cin_gt (cin_gt),
      .busy   (busy),
      .done   (done),
      .lt     (lt),
      .eq     (eq),
      .gt     (gt)
   );

   cmp_seq_ctrl #(.WIDTH(3)) u_dut3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start3),
      .a      (a3),
      .b      (b3),
      .cin_lt (1'b0),
      .cin_eq (1'b1),
      .cin_gt (1'b0),
      .busy   (busy3),
      .done   (done3),
      .lt     (lt3),
      .eq     (eq3),
      .gt     (gt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Whole-operand comparison; the seed only survives a full tie.
   function automatic logic [2:0] ref_cmp(input int unsigned av, input int unsigned bv,
                                          input logic [2:0] seed);
      if (av > bv) return 3'b001;
      if (av < bv) return 3'b100;
      return seed;
   endfunction

   task automatic do_cmp(input logic [8:0] av, input logic [8:0] bv, input logic [2:0] seed,
                         input string tag);
      int         n;
      logic [2:0] exp_res;
      exp_res = ref_cmp(av, bv, seed);
      @(negedge clk);
      a = av;
      b = bv;
      {cin_lt, cin_eq, cin_gt} = seed;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check($sformatf("%s_busy", tag), busy, 1);
      check($sformatf("%s_hold", tag), {lt, eq, gt}, exp_prev);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("%s_lat", tag), n, 3);
      check($sformatf("%s_res", tag), {lt, eq, gt}, exp_res);
      @(posedge clk);
      #1;
      check($sformatf("%s_pulse", tag), done, 0);
      exp_prev = exp_res;
   endtask

   initial begin
      int         n;
      int         m;
      logic       seen;
      logic [8:0] ra;
      logic [8:0] rb;
      logic [2:0] seeds [3];
      seeds[0] = 3'b001;
      seeds[1] = 3'b010;
      seeds[2] = 3'b100;
      n_checks = 0;
      n_pass   = 0;
      exp_prev = 3'b000;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      {cin_lt, cin_eq, cin_gt} = 3'b010;
      start3   = 1'b0;
      a3       = '0;
      b3       = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", {lt, eq, gt}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Equal operands: seed passes through
      do_cmp(9'o001, 9'o001, 3'b010, "eq_seed010");
      do_cmp(9'o001, 9'o001, 3'b100, "eq_seed100");
      do_cmp(9'o001, 9'o001, 3'b000, "eq_seed000");
      // Slice overrides
      do_cmp(9'o003, 9'o001, 3'b100, "low_gt");
      do_cmp(9'o100, 9'o077, 3'b010, "upper_gt");

      // Reset mid-RUN after leaving lt=1 held
      do_cmp(9'd5, 9'd9, 3'b010, "pre_rst");
      @(negedge clk);
      a = 9'd5;
      b = 9'd9;
      {cin_lt, cin_eq, cin_gt} = 3'b010;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_res", {lt, eq, gt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      check("mid_rst_no_done", seen, 0);
      exp_prev = 3'b000;

      // Start held through RUN with changing operands
      @(negedge clk);
      a = 9'o123;
      b = 9'o321;
      {cin_lt, cin_eq, cin_gt} = 3'b010;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 9'o777;
      b = 9'o000;
      n = 0;
      while (!done && n < 20) begin
         check("b2b_busy", busy, 1);
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b_lat1", n, 3);
      check("b2b_res1", {lt, eq, gt}, ref_cmp(9'o123, 9'o321, 3'b010));
      m = 0;
      do begin
         @(posedge clk);
         #1;
         m++;
         if (m == 1) begin
            start = 1'b0;
            check("b2b_accept", busy, 1);
         end
      end while (!done && m < 20);
      check("b2b_gap", m, 4);
      check("b2b_res2", {lt, eq, gt}, ref_cmp(9'o777, 9'o000, 3'b010));
      @(posedge clk);
      #1;
      exp_prev = ref_cmp(9'o777, 9'o000, 3'b010);

      // Randomized against the reference model
      for (int it = 0; it < 500; it++) begin
         ra = 9'($urandom_range(0, 511));
         rb = ($urandom_range(0, 3) == 0) ? ra : 9'($urandom_range(0, 511));
         if ($urandom_range(0, 3) == 0) rb[2:0] = ~ra[2:0];
         do_cmp(ra, rb, seeds[$urandom_range(0, 2)], "rand");
         check("rand_onehot", $countones({lt, eq, gt}), 1);
      end

      // WIDTH=3 instance: single slice
      @(negedge clk);
      a3 = 3'b000;
      b3 = 3'b001;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      check("w3_busy", busy3, 1);
      n = 0;
      while (!done3 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("w3_lat", n, 1);
      check("w3_res", {lt3, eq3, gt3}, 3'b100);
      @(negedge clk);
      a3 = 3'b101;
      b3 = 3'b010;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      n = 0;
      while (!done3 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("w3_lat2", n, 1);
      check("w3_res2", {lt3, eq3, gt3}, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
